// File: rtl/boot_loader.sv
// Framed byte-stream boot loader: SYNC, 16-bit little-endian length, payload, 8-bit additive checksum.
// Each accepted payload byte produces a registered one-cycle write strobe; the CPU is released only once the checksum matches.
module boot_loader #(
    parameter int          MEM_BYTES      = 1024,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        boot_wr_en,
    output logic [31:0] boot_wr_addr,
    output logic [7:0]  boot_wr_data,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        boot_error
);

    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     LEN_MAX  = 17'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;

    logic               accept;
    logic               in_frame;
    logic [15:0]        len_full;
    logic               len_bad;

    assign rx_ready = reset && (state_q != S_DONE) && (state_q != S_ERROR);
    assign accept   = rx_valid && rx_ready;
    assign in_frame = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        tmo_d     = '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        len_full  = {rx_data, len_q[7:0]};
        len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > LEN_MAX) ||
                    (len_full[1:0] != 2'b00);

        case (state_q)
            S_IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, rx_data};
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_bad) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d   = '0;
                        csum_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = 32'(cnt_q);
                    wr_data_d = rx_data;
                    csum_d    = csum_q + rx_data;
                    cnt_d     = cnt_q + 16'd1;
                    // Length is validated non-zero before entering DATA, so len_q-1 cannot underflow.
                    if (cnt_q == len_q - 16'd1) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: begin
            end
        endcase

        // A byte arriving on the expiry cycle takes precedence over the stall error.
        if (in_frame && !accept) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_ERROR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    assign boot_wr_en   = wr_en_q;
    assign boot_wr_addr = wr_addr_q;
    assign boot_wr_data = wr_data_q;
    assign cpu_hold     = (state_q != S_DONE);
    assign boot_done    = (state_q == S_DONE);
    assign boot_error   = (state_q == S_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Randomized and directed frames against a byte-level frame parser model; a write monitor checks strobes from a scoreboard queue.
module tb_boot_loader;

    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        boot_wr_en;
    logic [31:0] boot_wr_addr;
    logic [7:0]  boot_wr_data;
    logic        cpu_hold;
    logic        boot_done;
    logic        boot_error;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    boot_loader #(
        .MEM_BYTES     (1024),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .boot_wr_en  (boot_wr_en),
        .boot_wr_addr(boot_wr_addr),
        .boot_wr_data(boot_wr_data),
        .cpu_hold    (cpu_hold),
        .boot_done   (boot_done),
        .boot_error  (boot_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (boot_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr: got addr %h data %h expected no write", boot_wr_addr, boot_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr", 64'({boot_wr_addr, boot_wr_data}), 64'({e.a, e.d}));
            end
        end
    end

    // Frame parser: returns bytes the loader will consume and the outcome (0 in progress, 1 done, 2 error).
    task automatic model(input logic [7:0] s[$], output int n, output int oc);
        int p;
        int len;
        int sum;
        wr_t e;
        p   = 0;
        sum = 0;
        n   = s.size();
        oc  = 0;
        while (p < s.size() && s[p] != 8'hA5) p++;
        if (p + 3 > s.size()) return;
        len = int'({s[p+2], s[p+1]});
        p   = p + 3;
        if (len == 0 || len > 1024 || (len % 4) != 0) begin
            n  = p;
            oc = 2;
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (p >= s.size()) return;
            e.a = 32'(i);
            e.d = s[p];
            exp_q.push_back(e);
            sum = sum + int'(s[p]);
            p++;
        end
        if (p >= s.size()) return;
        n  = p + 1;
        oc = (s[p] == 8'(sum)) ? 1 : 2;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int w;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        w = 0;
        while (!rx_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got rx_ready 0 expected 1 for byte %h", b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_status(input string name, input int oc);
        @(negedge clk);
        #1;
        chk({name, "_status"}, 64'({rx_ready, cpu_hold, boot_done, boot_error}),
            64'({oc == 0, oc != 1, oc == 1, oc == 2}));
        chk({name, "_pending_wr"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_outputs",
            64'({rx_ready, boot_wr_en, boot_wr_addr, boot_wr_data, cpu_hold, boot_done, boot_error}),
            64'({1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0}));
        chk("reset_pending_wr", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        reset = 1'b1;
    endtask

    task automatic run_stream(input string name, input logic [7:0] s[$], input int gap_max);
        int n;
        int oc;
        model(s, n, oc);
        for (int i = 0; i < n; i++) send(s[i], $urandom_range(0, gap_max));
        check_status(name, oc);
    endtask

    task automatic add_nominal(inout logic [7:0] s[$], input logic [7:0] ck);
        logic [7:0] nom [8];
        nom = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        s.push_back(8'hA5);
        s.push_back(8'h08);
        s.push_back(8'h00);
        for (int i = 0; i < 8; i++) s.push_back(nom[i]);
        s.push_back(ck);
    endtask

    task automatic add_random_frame(inout logic [7:0] s[$]);
        int         len;
        int         sum;
        logic [7:0] b;
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
            b = 8'($urandom);
            s.push_back((b == 8'hA5) ? 8'h00 : b);
        end
        if ($urandom_range(0, 9) < 8) begin
            len = 4 * $urandom_range(1, 16);
        end else begin
            case ($urandom_range(0, 4))
                0:       len = 0;
                1:       len = 6;
                2:       len = 1028;
                3:       len = 1025;
                default: len = 4 * $urandom_range(257, 400);
            endcase
        end
        s.push_back(8'hA5);
        s.push_back(8'(len));
        s.push_back(8'(len >> 8));
        sum = 0;
        if (len > 0 && len <= 1024 && (len % 4) == 0) begin
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                s.push_back(b);
                sum = sum + int'(b);
            end
            if ($urandom_range(0, 3) == 0) s.push_back(8'(sum + $urandom_range(1, 255)));
            else                           s.push_back(8'(sum));
        end
    endtask

    initial begin
        logic [7:0] s[$];
        int         n;
        int         oc;
        int         first_err;

        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("initial_reset", 64'({rx_ready, boot_wr_en, boot_wr_addr, boot_wr_data, cpu_hold, boot_done, boot_error}),
            64'({1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0}));
        reset = 1'b1;

        s.delete(); add_nominal(s, 8'hB6);
        run_stream("nominal", s, 0);
        do_reset();

        s.delete();
        s.push_back(8'h00); s.push_back(8'hFF); s.push_back(8'h5A);
        add_nominal(s, 8'hB6);
        run_stream("garbage", s, 2);
        do_reset();

        s.delete(); s.push_back(8'hA5); s.push_back(8'h06); s.push_back(8'h00);
        run_stream("len6", s, 1);
        do_reset();

        s.delete(); s.push_back(8'hA5); s.push_back(8'h04); s.push_back(8'h04);
        run_stream("len1028", s, 1);
        do_reset();

        s.delete(); add_nominal(s, 8'hB7);
        run_stream("bad_csum", s, 1);
        do_reset();

        s.delete();
        s.push_back(8'hA5); s.push_back(8'h04); s.push_back(8'h00); s.push_back(8'h3C);
        model(s, n, oc);
        for (int i = 0; i < n; i++) send(s[i], 0);
        first_err = -1;
        for (int i = 0; i < TMO + 6; i++) begin
            @(negedge clk);
            if (boot_error === 1'b1 && first_err < 0) first_err = i;
        end
        chk("timeout_cycle", 64'(first_err), 64'(TMO));
        check_status("timeout", 2);
        do_reset();

        s.delete();
        s.push_back(8'hA5); s.push_back(8'h04); s.push_back(8'h00);
        s.push_back(8'h11); s.push_back(8'h22);
        run_stream("midframe", s, 1);
        do_reset();
        s.delete(); add_nominal(s, 8'hB6);
        run_stream("after_reset", s, 1);
        do_reset();

        s.delete();
        begin
            int         sum;
            logic [7:0] b;
            sum = 0;
            s.push_back(8'hA5); s.push_back(8'h00); s.push_back(8'h04);
            for (int i = 0; i < 1024; i++) begin
                b = 8'($urandom);
                s.push_back(b);
                sum = sum + int'(b);
            end
            s.push_back(8'(sum));
        end
        run_stream("len1024", s, 0);
        do_reset();

        for (int f = 0; f < 40; f++) begin
            s.delete();
            add_random_frame(s);
            run_stream("random", s, 3);
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
